ps2_rx_apb_fifo: RTL and testbench

Parametrised second-generation PS/2 keyboard receiver with an APB slave port. It deserialises 11-bit PS/2 device-to-host frames into scan codes and buffers them in a configurable-depth FIFO. It adds a glitch filter on ps2_clk, sticky error reporting (overflow, parity, framing), write-1-to-clear status, a control register and a level interrupt. It sits on the SoC APB peripheral bus next to the UART and GPIO slaves.

---
 rtl/ps2_rx_apb_fifo_if.sv | 29 ++
 rtl/ps2_rx_apb_fifo.sv | 196 +++++++++++++++++++
 tb/tb_ps2_rx_apb_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_apb_fifo_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : ps2_rx_apb_fifo_if
// | Purpose  : APB slave bus bundle for the PS/2 receiver peripheral.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
interface ps2_rx_apb_fifo_if;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic        in_pwrite;
    logic [2:0]  in_pprot;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    modport master (
        output in_paddr, in_psel, in_penable, in_pwrite, in_pprot, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );

    modport slave (
        input  in_paddr, in_psel, in_penable, in_pwrite, in_pprot, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr
    );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_apb_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : ps2_rx_apb_fifo
// | Purpose  : PS/2 device-to-host receiver with glitch filter, scan-code FIFO
// |            and APB register interface with sticky errors and level irq.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
module ps2_rx_apb_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic             clock,
    input  logic             reset,
    ps2_rx_apb_fifo_if.slave apb,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             irq
);
    localparam int C_AW = $clog2(FIFO_DEPTH);
    localparam int C_TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_DATA   = 2'd1;
    localparam logic [1:0] C_ST_PARITY = 2'd2;
    localparam logic [1:0] C_ST_STOP   = 2'd3;

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_flt_clk, r_flt_prev;
    logic [3:0]      r_flt_cnt;
    logic [C_TW-1:0] r_to_cnt;
    logic [1:0]      r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [C_AW-1:0] r_wptr, r_rptr;
    logic [C_AW:0]   r_count;
    logic            r_ovf, r_perr, r_ferr;
    logic            r_rx_en, r_irq_en;

    logic w_strobe, w_to_sat, w_stop_strobe, w_good, w_push, w_wr_en;
    logic w_empty, w_full, w_access, w_pop, w_wr;
    logic w_wr_status, w_wr_ctrl, w_ovf_set, w_perr_set, w_ferr_set;
    logic [31:0] w_status;
    logic w_unused;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flt_clk  <= 1'b1;
            r_flt_prev <= 1'b1;
            r_flt_cnt  <= 4'd0;
        end else begin
            r_flt_prev <= r_flt_clk;
            if (r_clk_s2 == r_flt_clk) begin
                r_flt_cnt <= 4'd0;
            end else if (r_flt_cnt == 4'(FILTER_LEN - 1)) begin
                r_flt_clk <= r_clk_s2;
                r_flt_cnt <= 4'd0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 4'd1;
            end
        end
    end

    assign w_strobe      = r_flt_prev & ~r_flt_clk;
    assign w_to_sat      = (r_to_cnt == C_TW'(TIMEOUT_CYCLES));
    assign w_stop_strobe = r_rx_en & w_strobe & (r_state == C_ST_STOP);
    assign w_good        = r_dat_s2 & (^{r_shift, r_parity});
    assign w_push        = w_stop_strobe & w_good;
    assign w_perr_set    = w_stop_strobe & r_dat_s2 & ~(^{r_shift, r_parity});
    assign w_ferr_set    = w_stop_strobe & ~r_dat_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_state   <= C_ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
        end else begin
            if (w_strobe)
                r_to_cnt <= '0;
            else if (!w_to_sat)
                r_to_cnt <= r_to_cnt + C_TW'(1);

            if (!r_rx_en) begin
                r_state <= C_ST_IDLE;
            end else if (w_strobe) begin
                case (r_state)
                    C_ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= C_ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    C_ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= C_ST_PARITY;
                    end
                    C_ST_PARITY: begin
                        r_parity <= r_dat_s2;
                        r_state  <= C_ST_STOP;
                    end
                    default: r_state <= C_ST_IDLE;
                endcase
            end else if (w_to_sat && r_state != C_ST_IDLE) begin
                r_state <= C_ST_IDLE;
            end
        end
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (C_AW + 1)'(FIFO_DEPTH));
    assign w_access    = apb.in_psel & apb.in_penable;
    assign w_pop       = w_access & ~apb.in_pwrite & (apb.in_paddr[3:2] == 2'd0) & ~w_empty;
    assign w_wr        = w_access & apb.in_pwrite & apb.in_pstrb[0];
    assign w_wr_status = w_wr & (apb.in_paddr[3:2] == 2'd1);
    assign w_wr_ctrl   = w_wr & (apb.in_paddr[3:2] == 2'd2);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_wr_en     = w_push & (~w_full | w_pop);
    assign w_ovf_set   = w_push & w_full & ~w_pop;

    always_ff @(posedge clock) begin
        if (w_wr_en)
            r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_rx_en  <= 1'b1;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wptr <= r_wptr + C_AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + C_AW'(1);
            if (w_wr_en && !w_pop)
                r_count <= r_count + (C_AW + 1)'(1);
            else if (!w_wr_en && w_pop)
                r_count <= r_count - (C_AW + 1)'(1);

            r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_wr_status & apb.in_pwdata[2]));
            r_perr <= w_perr_set | (r_perr & ~(w_wr_status & apb.in_pwdata[3]));
            r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_status & apb.in_pwdata[4]));

            if (w_wr_ctrl) begin
                r_rx_en  <= apb.in_pwdata[0];
                r_irq_en <= apb.in_pwdata[1];
            end
        end
    end

    assign w_status = (32'(r_count) << 8) | {27'd0, r_ferr, r_perr, r_ovf, w_full, w_empty};

    always_comb begin
        apb.in_prdata = 32'd0;
        case (apb.in_paddr[3:2])
            2'd0:    if (!w_empty) apb.in_prdata = {23'd0, 1'b1, r_mem[r_rptr]};
            2'd1:    apb.in_prdata = w_status;
            2'd2:    apb.in_prdata = {30'd0, r_irq_en, r_rx_en};
            default: apb.in_prdata = 32'd0;
        endcase
    end

    assign apb.in_pready  = 1'b1;
    assign apb.in_pslverr = w_access & (apb.in_paddr[3:2] == 2'd3);
    assign irq            = r_irq_en & (~w_empty | r_ovf | r_perr | r_ferr);

    assign w_unused = &{1'b0, apb.in_pprot, apb.in_paddr[31:4], apb.in_paddr[1:0],
                        apb.in_pwdata[31:5], apb.in_pstrb[3:1]};
endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_apb_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : tb_ps2_rx_apb_fifo
// | Purpose  : Directed bench for ps2_rx_apb_fifo with a read-data scoreboard.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_ps2_rx_apb_fifo;
    localparam int C_DEPTH = 16;
    localparam int C_TO    = 300;
    localparam int C_FLT   = 4;
    localparam int C_H     = 20;

    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_BAD = 32'hC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic irq;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    string       name_q[$];

    ps2_rx_apb_fifo_if bus();

    ps2_rx_apb_fifo #(
        .FIFO_DEPTH(C_DEPTH),
        .TIMEOUT_CYCLES(C_TO),
        .FILTER_LEN(C_FLT)
    ) dut (
        .clock(clk),
        .reset(rst),
        .apb(bus.slave),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required finish before 2000000");
        $fatal(1);
    end

    // Scoreboard monitor: every APB read access phase pops one expected {pslverr, prdata}.
    always @(negedge clk) begin
        logic [32:0] e;
        string n;
        #3;
        if (bus.in_psel && bus.in_penable && !bus.in_pwrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: actual addr %h, required no read", bus.in_paddr);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if ({bus.in_pslverr, bus.in_prdata} !== e)
                begin
                    errors++;
                    $display("FAIL %s: actual %h, required %h", n,
                             {bus.in_pslverr, bus.in_prdata}, e);
                end
            end
        end
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h, required %h", n, act, exp);
        end
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [32:0] exp, input string n);
        exp_q.push_back(exp);
        name_q.push_back(n);
        @(negedge clk);
        bus.in_paddr = a; bus.in_pwrite = 1'b0; bus.in_psel = 1'b1; bus.in_penable = 1'b0;
        @(negedge clk);
        bus.in_penable = 1'b1;
        @(negedge clk);
        bus.in_psel = 1'b0; bus.in_penable = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.in_paddr = a; bus.in_pwdata = d; bus.in_pstrb = s;
        bus.in_pwrite = 1'b1; bus.in_psel = 1'b1; bus.in_penable = 1'b0;
        @(negedge clk);
        bus.in_penable = 1'b1;
        @(negedge clk);
        bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pwrite = 1'b0;
    endtask

    // Drives the first nbits bits of a frame: start, 8 data LSB first, odd parity, stop.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (C_H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (C_H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (C_H) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    initial begin
        bus.in_paddr = '0; bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pwrite = 1'b0;
        bus.in_pprot = '0; bus.in_pwdata = '0; bus.in_pstrb = 4'hF;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_irq", 32'(irq), 32'd0);
        check("reset_pready", 32'(bus.in_pready), 32'd1);
        check("reset_pslverr", 32'(bus.in_pslverr), 32'd0);
        apb_read(A_STAT, {1'b0, 32'h1}, "reset_status");
        apb_read(A_CTRL, {1'b0, 32'h1}, "reset_ctrl");
        apb_read(A_DATA, {1'b0, 32'h0}, "reset_data_empty");

        send_frame(8'h1C, 1'b0, 1'b1, 11);
        apb_read(A_STAT, {1'b0, 32'h100}, "good_status");
        apb_read(A_DATA, {1'b0, 32'h11C}, "good_data");
        apb_read(A_DATA, {1'b0, 32'h0}, "good_data_after_pop");
        apb_read(A_STAT, {1'b0, 32'h1}, "good_status_empty");

        send_frame(8'h1C, 1'b1, 1'b1, 11);
        apb_read(A_STAT, {1'b0, 32'h9}, "perr_status");
        apb_write(A_STAT, 32'h8, 4'hF);
        apb_read(A_STAT, {1'b0, 32'h1}, "perr_cleared");

        for (int i = 0; i <= C_DEPTH; i++)
            send_frame(8'(i), 1'b0, 1'b1, 11);
        apb_read(A_STAT, {1'b0, 32'h1006}, "full_ovf_status");
        apb_write(A_STAT, 32'h4, 4'hE);
        apb_read(A_STAT, {1'b0, 32'h1006}, "clear_without_strobe0");
        for (int i = 0; i < C_DEPTH; i++)
            apb_read(A_DATA, {1'b0, 32'h100 + 32'(i)}, "fifo_order");
        apb_read(A_STAT, {1'b0, 32'h5}, "drained_ovf_sticky");
        apb_write(A_STAT, 32'h4, 4'h1);
        apb_read(A_STAT, {1'b0, 32'h1}, "ovf_cleared");

        ps2_data = 1'b0;
        for (int g = 1; g < C_FLT; g++) begin
            @(negedge clk);
            ps2_clk = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 11);
        apb_read(A_DATA, {1'b0, 32'h15A}, "after_glitch_data");
        send_frame(8'h33, 1'b0, 1'b0, 11);
        apb_read(A_STAT, {1'b0, 32'h11}, "ferr_status");
        apb_write(A_STAT, 32'h10, 4'hF);
        apb_read(A_STAT, {1'b0, 32'h1}, "ferr_cleared");

        send_frame(8'hAA, 1'b0, 1'b1, 4);
        repeat (C_TO + 20) @(negedge clk);
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        apb_read(A_DATA, {1'b0, 32'h1F0}, "after_timeout_data");
        apb_read(A_STAT, {1'b0, 32'h1}, "after_timeout_status");

        apb_write(A_CTRL, 32'h2, 4'hF);
        apb_read(A_CTRL, {1'b0, 32'h2}, "ctrl_rx_off");
        send_frame(8'h44, 1'b0, 1'b1, 11);
        apb_read(A_STAT, {1'b0, 32'h1}, "rx_off_no_push");
        check("rx_off_irq", 32'(irq), 32'd0);

        apb_write(A_CTRL, 32'h3, 4'hF);
        send_frame(8'h44, 1'b0, 1'b1, 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (C_H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("irq_before_push", 32'(irq), 32'd0);
        @(posedge clk);
        #1 check("irq_after_push", 32'(irq), 32'd1);
        repeat (C_H) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (C_H) @(negedge clk);
        apb_read(A_CTRL, {1'b0, 32'h3}, "ctrl_readback");
        apb_read(A_DATA, {1'b0, 32'h144}, "irq_frame_data");
        check("irq_after_pop", 32'(irq), 32'd0);
        apb_read(A_BAD, {1'b1, 32'h0}, "bad_addr_slverr");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
